// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: in-order ROB head commit sequencer (ALU writeback, stores, exception flush)
module rob_commit_ctrl #(
  parameter int DATA_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rob_valid,
  input  logic [DATA_W-1:0] rob_val,
  input  logic [4:0]        rob_rd,
  input  logic              rob_store,
  input  logic [DATA_W-1:0] rob_addr,
  input  logic              rob_ex,
  input  logic [DATA_W-1:0] rob_epc,
  output logic              next_head,
  output logic              rf_we,
  output logic [4:0]        rf_rd,
  output logic [DATA_W-1:0] rf_val,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              flush,
  output logic [DATA_W-1:0] epc_out,
  output logic [31:0]       commit_count
);
  typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;
  state_t state, state_nx;
  logic [31:0] fcnt;
  logic alu;
  always_comb begin
    alu       = !rst && state == RUN && rob_valid && !rob_ex && !rob_store;
    next_head = alu || (!rst && state == STORE_WAIT && mem_ack);
    rf_we     = alu && rob_rd != 5'd0;
    rf_rd     = rob_rd;
    rf_val    = rob_val;
    state_nx  = state;
    if (state == RUN && rob_valid) state_nx = rob_ex ? FLUSH : rob_store ? STORE_WAIT : RUN;
    else if (state == STORE_WAIT && mem_ack) state_nx = RUN;
    else if (state == FLUSH && fcnt == 32'd0) state_nx = RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      flush        <= 1'b0;
      epc_out      <= '0;
      commit_count <= 32'd0;
      fcnt         <= 32'd0;
    end else begin
      state <= state_nx;
      if (next_head) commit_count <= commit_count + 32'd1;
      // exception outranks a store on the same head entry
      if (state == RUN && rob_valid && rob_ex) begin
        epc_out <= rob_epc;
        flush   <= 1'b1;
        fcnt    <= 32'(FLUSH_CYCLES - 1);
      end else if (state == RUN && rob_valid && rob_store) begin
        mem_addr <= rob_addr;
        mem_data <= rob_val;
        mem_req  <= 1'b1;
      end
      if (state == STORE_WAIT && mem_ack) mem_req <= 1'b0;
      if (state == FLUSH) begin
        if (fcnt == 32'd0) flush <= 1'b0;
        else fcnt <= fcnt - 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb_rob_commit_ctrl: table vectors, directed corner sequences and random traffic vs a transaction-level model
module tb_rob_commit_ctrl;
  localparam int DW = 32;
  localparam int FC = 2;
  logic clk = 0, rst;
  logic rob_valid, rob_store, rob_ex, mem_ack;
  logic [DW-1:0] rob_val, rob_addr, rob_epc;
  logic [4:0] rob_rd;
  logic next_head, rf_we, mem_req, flush;
  logic [4:0] rf_rd;
  logic [DW-1:0] rf_val, mem_addr, mem_data, epc_out;
  logic [31:0] commit_count;
  int checks = 0, failures = 0;

  rob_commit_ctrl #(.DATA_W(DW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .rob_valid(rob_valid), .rob_val(rob_val), .rob_rd(rob_rd),
    .rob_store(rob_store), .rob_addr(rob_addr), .rob_ex(rob_ex), .rob_epc(rob_epc),
    .next_head(next_head), .rf_we(rf_we), .rf_rd(rf_rd), .rf_val(rf_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .flush(flush), .epc_out(epc_out), .commit_count(commit_count));

  always #5 clk = ~clk;

  // transaction-level model: a store in flight, remaining flush cycles, retire count
  bit          m_store;
  int          m_flush_left;
  int unsigned m_cnt;
  logic [DW-1:0] m_addr, m_data, m_epc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_store = 0; m_flush_left = 0; m_cnt = 0; m_addr = 0; m_data = 0; m_epc = 0;
  endtask

  // called just after a negedge with inputs applied; checks, then advances one clock
  task automatic cyc();
    bit idle_run, retire, wr;
    #1;
    idle_run = !m_store && m_flush_left == 0;
    retire = !rst && (idle_run ? (rob_valid && !rob_ex && !rob_store) : (m_store && mem_ack));
    wr = !rst && idle_run && rob_valid && !rob_ex && !rob_store && rob_rd != 0;
    chk("next_head", 32'(next_head), 32'(retire));
    chk("rf_we", 32'(rf_we), 32'(wr));
    if (wr) begin
      chk("rf_rd", 32'(rf_rd), 32'(rob_rd));
      chk("rf_val", rf_val, rob_val);
    end
    chk("mem_req", 32'(mem_req), 32'(m_store));
    if (m_store) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data", mem_data, m_data);
    end
    chk("flush", 32'(flush), 32'(m_flush_left > 0));
    chk("epc_out", epc_out, m_epc);
    chk("commit_count", commit_count, m_cnt);
    @(posedge clk);
    if (rst) model_reset();
    else if (m_store) begin
      if (mem_ack) begin m_store = 0; m_cnt++; end
    end else if (m_flush_left > 0) m_flush_left--;
    else if (rob_valid) begin
      if (rob_ex) begin m_epc = rob_epc; m_flush_left = FC; end
      else if (rob_store) begin m_addr = rob_addr; m_data = rob_val; m_store = 1; end
      else m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic drive(logic v, logic [31:0] val, logic [4:0] rd, logic st,
                       logic [31:0] addr, logic ex, logic [31:0] epc, logic ack);
    rob_valid = v; rob_val = val; rob_rd = rd; rob_store = st;
    rob_addr = addr; rob_ex = ex; rob_epc = epc; mem_ack = ack;
  endtask

  typedef struct {
    logic v; logic [31:0] val; logic [4:0] rd; logic ack;
    logic nh; logic we; logic [31:0] cnt;
  } tv_t;
  tv_t tv [5];

  initial begin
    tv[0] = '{1, 32'h11, 5'd5, 0, 1, 1, 32'd0};
    tv[1] = '{1, 32'h22, 5'd0, 0, 1, 0, 32'd1};
    tv[2] = '{1, 32'h33, 5'd7, 0, 1, 1, 32'd2};
    tv[3] = '{0, 32'h0,  5'd0, 1, 0, 0, 32'd3};
    tv[4] = '{0, 32'h0,  5'd0, 0, 0, 0, 32'd3};
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset flush", 32'(flush), 0);
    chk("reset count", commit_count, 0);
    chk("reset epc", epc_out, 0);
    chk("reset mem_addr", mem_addr, 0);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      drive(tv[i].v, tv[i].val, tv[i].rd, 0, 0, 0, 0, tv[i].ack);
      #1;
      chk($sformatf("tv%0d next_head", i), 32'(next_head), 32'(tv[i].nh));
      chk($sformatf("tv%0d rf_we", i), 32'(rf_we), 32'(tv[i].we));
      if (tv[i].we) chk($sformatf("tv%0d rf_rd", i), 32'(rf_rd), 32'(tv[i].rd));
      chk($sformatf("tv%0d count", i), commit_count, tv[i].cnt);
      cyc();
    end

    // store with ack delayed; head inputs change meanwhile and must be ignored
    drive(1, 32'hABCD, 5'd3, 1, 32'h100, 0, 0, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h5555, 5'd9, 0, 32'h200, 0, 0, i == 2);
      #1;
      chk("st mem_req", 32'(mem_req), 1);
      chk("st mem_addr", mem_addr, 32'h100);
      chk("st mem_data", mem_data, 32'hABCD);
      chk("st next_head", 32'(next_head), 32'(i == 2));
      chk("st rf_we", 32'(rf_we), 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("st done mem_req", 32'(mem_req), 0);
    chk("st done count", commit_count, 32'd4);
    cyc();

    // exception beats store
    drive(1, 32'h77, 5'd4, 1, 32'h300, 1, 32'h40, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ex flush", 32'(flush), 32'(i < 2));
      chk("ex mem_req", 32'(mem_req), 0);
      chk("ex epc", epc_out, 32'h40);
      chk("ex count", commit_count, 32'd4);
      chk("ex next_head", 32'(next_head), 0);
      cyc();
    end

    // reset during the second STORE_WAIT cycle
    drive(1, 32'h9, 5'd1, 1, 32'h80, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    #1;
    chk("rst sw mem_req", 32'(mem_req), 0);
    chk("rst sw count", commit_count, 0);
    chk("rst sw next_head", 32'(next_head), 0);
    cyc();

    // count wrap using a forced preload
    force dut.commit_count = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.commit_count;
    m_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("wrap pre", commit_count, 32'hFFFF_FFFF);
    drive(1, 32'h1, 5'd2, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap post", commit_count, 32'd0);
    cyc();

    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 9) < 7, $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 9) == 0,
            $urandom, $urandom_range(0, 9) < 4);
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
